alu_issue_ctrl: RTL and testbench

//  Sequences the shared 32-bit ALU between two requesters (0 = decode/issue, 1 = address gen).

---
 rtl/alu_issue_ctrl_pkg.sv | 44 ++++
 rtl/alu_issue_ctrl_rr_arbiter2.sv | 29 ++
 rtl/alu_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// ============================================================================
//  Module      : alu_issue_ctrl_pkg
//  Description : Shared ALU op-codes, FSM state encodings and the op-code
//                support check used by the ALU issue controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_issue_ctrl_pkg;

    // ALU control codes as seen on the ALU cnt input
    localparam logic [11:0] c_op_add  = 12'd32;
    localparam logic [11:0] c_op_addi = 12'd512;
    localparam logic [11:0] c_op_sub  = 12'd34;
    localparam logic [11:0] c_op_mul  = 12'd24;
    localparam logic [11:0] c_op_div  = 12'd26;
    localparam logic [11:0] c_op_and  = 12'd36;
    localparam logic [11:0] c_op_andi = 12'd768;
    localparam logic [11:0] c_op_or   = 12'd37;
    localparam logic [11:0] c_op_ori  = 12'd832;
    localparam logic [11:0] c_op_lw   = 12'd2048;
    localparam logic [11:0] c_op_sw   = 12'd2560;

    // Issue FSM state encodings
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // True when the ALU produces a defined result for this code.
    // The register-form OR has no ALU implementation and is flagged.
    function automatic logic op_supported(input logic [11:0] cnt);
        logic ok;
        case (cnt)
            c_op_add, c_op_addi, c_op_sub, c_op_mul, c_op_div,
            c_op_and, c_op_andi, c_op_ori, c_op_lw, c_op_sw: ok = 1'b1;
            c_op_or:                                         ok = 1'b0;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_rr_arbiter2.sv
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way combinational round-robin arbiter. A lone request
//                wins outright; on a tie the requester that did not win
//                last time is granted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // One-hot grant; ties go to the requester opposite to 'last'
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Shares one 32-bit ALU between two requesters. Arbitrates
//                round-robin, holds ALU inputs stable for the op latency,
//                captures the result and returns it on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [23:0] req_cnt_i,
    input  logic [63:0] req_rs_i,
    input  logic [63:0] req_rt_i,
    input  logic [63:0] req_imm_i,
    output logic [11:0] alu_cnt_o,
    output logic [31:0] alu_rs_o,
    output logic [31:0] alu_rt_o,
    output logic [31:0] alu_imm_o,
    input  logic [31:0] alu_out_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_id_o,
    output logic        rsp_err_o
);

    // The counter only ever holds LAT-1, so the longest latency sets its width
    localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_lat_w   = (c_max_lat > 1) ? $clog2(c_max_lat) : 1;

    logic [1:0]         r_state;
    logic               r_last_grant;
    logic [11:0]        r_cnt;
    logic [31:0]        r_rs;
    logic [31:0]        r_rt;
    logic [31:0]        r_imm;
    logic               r_id;
    logic [c_lat_w-1:0] r_lat_cnt;
    logic [31:0]        r_data;
    logic               r_err;

    logic [1:0]         w_gnt;
    logic               w_idle;
    logic               w_exec;
    logic               w_accept;
    logic               w_sel_id;
    logic [11:0]        w_sel_cnt;
    logic [31:0]        w_sel_rs;
    logic [31:0]        w_sel_rt;
    logic [31:0]        w_sel_imm;
    logic [c_lat_w-1:0] w_load_lat;

    rr_arbiter2 u_arb (
        .req  (req_valid_i),
        .last (r_last_grant),
        .gnt  (w_gnt)
    );

    assign w_idle   = (r_state == c_st_idle);
    assign w_exec   = (r_state == c_st_exec);
    // A grant only exists for a valid requester, so any grant in IDLE is a handshake
    assign w_accept = w_idle && (w_gnt != 2'b00);
    assign w_sel_id = w_gnt[1];

    assign w_sel_cnt = w_sel_id ? req_cnt_i[23:12] : req_cnt_i[11:0];
    assign w_sel_rs  = w_sel_id ? req_rs_i[63:32]  : req_rs_i[31:0];
    assign w_sel_rt  = w_sel_id ? req_rt_i[63:32]  : req_rt_i[31:0];
    assign w_sel_imm = w_sel_id ? req_imm_i[63:32] : req_imm_i[31:0];

    // Number of EXEC cycles minus one for the selected op
    always_comb begin
        w_load_lat = '0;
        case (w_sel_cnt)
            c_op_mul: w_load_lat = c_lat_w'(MUL_LAT - 1);
            c_op_div: w_load_lat = c_lat_w'(DIV_LAT - 1);
            default:  w_load_lat = '0;
        endcase
    end

    // Issue FSM with operand capture, latency count and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_imm        <= '0;
            r_id         <= 1'b0;
            r_lat_cnt    <= '0;
            r_data       <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_cnt        <= w_sel_cnt;
                        r_rs         <= w_sel_rs;
                        r_rt         <= w_sel_rt;
                        r_imm        <= w_sel_imm;
                        r_id         <= w_sel_id;
                        r_last_grant <= w_sel_id;
                        if ((w_sel_cnt == c_op_div) && (w_sel_rt == 32'd0)) begin
                            // Divide by zero never reaches the ALU
                            r_data  <= '0;
                            r_err   <= 1'b1;
                            r_state <= c_st_done;
                        end else begin
                            r_lat_cnt <= w_load_lat;
                            r_err     <= !op_supported(w_sel_cnt);
                            r_state   <= c_st_exec;
                        end
                    end
                end
                c_st_exec: begin
                    if (r_lat_cnt == '0) begin
                        r_data  <= alu_out_i;
                        r_state <= c_st_done;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                c_st_done: begin
                    if (rsp_ready_i) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // ALU sees a zero code (and zero operands) whenever it is not executing
    assign alu_cnt_o = w_exec ? r_cnt : 12'd0;
    assign alu_rs_o  = w_exec ? r_rs  : 32'd0;
    assign alu_rt_o  = w_exec ? r_rt  : 32'd0;
    assign alu_imm_o = w_exec ? r_imm : 32'd0;

    assign req_ready_o = w_idle ? w_gnt : 2'b00;
    assign rsp_valid_o = (r_state == c_st_done);
    assign rsp_data_o  = r_data;
    assign rsp_id_o    = r_id;
    assign rsp_err_o   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Directed self-checking bench for alu_issue_ctrl with a
//                behavioural ALU model on the ALU side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [23:0] req_cnt_i;
    logic [63:0] req_rs_i;
    logic [63:0] req_rt_i;
    logic [63:0] req_imm_i;
    logic [11:0] alu_cnt_o;
    logic [31:0] alu_rs_o;
    logic [31:0] alu_rt_o;
    logic [31:0] alu_imm_o;
    logic [31:0] alu_out_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_id_o;
    logic        rsp_err_o;

    int n_checks;
    int n_errors;

    alu_issue_ctrl #(
        .MUL_LAT (4),
        .DIV_LAT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_cnt_i   (req_cnt_i),
        .req_rs_i    (req_rs_i),
        .req_rt_i    (req_rt_i),
        .req_imm_i   (req_imm_i),
        .alu_cnt_o   (alu_cnt_o),
        .alu_rs_o    (alu_rs_o),
        .alu_rt_o    (alu_rt_o),
        .alu_imm_o   (alu_imm_o),
        .alu_out_i   (alu_out_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_err_o   (rsp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: combinational, returns 0 for unknown codes and cnt=0
    always_comb begin
        alu_out_i = 32'd0;
        case (alu_cnt_o)
            12'd32:   alu_out_i = alu_rs_o + alu_rt_o;
            12'd512:  alu_out_i = alu_rs_o + alu_imm_o;
            12'd34:   alu_out_i = alu_rs_o - alu_rt_o;
            12'd24:   alu_out_i = alu_rs_o * alu_rt_o;
            12'd26:   alu_out_i = (alu_rt_o != 32'd0) ? alu_rs_o / alu_rt_o : 32'd0;
            12'd36:   alu_out_i = alu_rs_o & alu_rt_o;
            12'd768:  alu_out_i = alu_rs_o & alu_imm_o;
            12'd832:  alu_out_i = alu_rs_o | alu_imm_o;
            12'd2048: alu_out_i = alu_rs_o + alu_imm_o;
            12'd2560: alu_out_i = alu_rs_o + alu_imm_o;
            default:  alu_out_i = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [11:0] cnt, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] imm);
        if (id == 0) begin
            req_cnt_i[11:0] = cnt;
            req_rs_i[31:0]  = rs;
            req_rt_i[31:0]  = rt;
            req_imm_i[31:0] = imm;
            req_valid_i[0]  = 1'b1;
        end else begin
            req_cnt_i[23:12] = cnt;
            req_rs_i[63:32]  = rs;
            req_rt_i[63:32]  = rt;
            req_imm_i[63:32] = imm;
            req_valid_i[1]   = 1'b1;
        end
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 40 && !rsp_valid_o; i++) begin
            @(posedge clk); #1;
        end
        check("rsp_timeout", {31'd0, rsp_valid_o}, 32'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        check("rsp_drop", {31'd0, rsp_valid_o}, 32'd0);
    endtask

    // Expect requester 'id' to be granted, then check its response
    task automatic serve(input int id, input logic [31:0] exp_data, input logic exp_err);
        #1;
        check("grant", {30'd0, req_ready_o}, (id == 0) ? 32'd1 : 32'd2);
        @(posedge clk); #1;
        req_valid_i[id] = 1'b0;
        wait_rsp();
        check("data", rsp_data_o, exp_data);
        check("id", {31'd0, rsp_id_o}, id[31:0]);
        check("err", {31'd0, rsp_err_o}, {31'd0, exp_err});
        finish_rsp();
    endtask

    initial begin
        logic seen_valid;
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        req_valid_i = 2'b00;
        req_cnt_i   = '0;
        req_rs_i    = '0;
        req_rt_i    = '0;
        req_imm_i   = '0;
        rsp_ready_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_data", rsp_data_o, 32'd0);
        check("rst_alu_cnt", {20'd0, alu_cnt_o}, 32'd0);
        check("rst_ready", {30'd0, req_ready_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single ADD, exact latency
        set_req(0, 12'd32, 32'd120, 32'd145, 32'd0);
        #1;
        check("t1_ready", {30'd0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
        req_valid_i[0] = 1'b0;
        check("t1_alu_cnt", {20'd0, alu_cnt_o}, 32'd32);
        check("t1_not_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("t1_ready_exec", {30'd0, req_ready_o}, 32'd0);
        @(posedge clk); #1;
        check("t1_valid", {31'd0, rsp_valid_o}, 32'd1);
        check("t1_data", rsp_data_o, 32'd265);
        check("t1_id", {31'd0, rsp_id_o}, 32'd0);
        check("t1_err", {31'd0, rsp_err_o}, 32'd0);
        finish_rsp();

        // Re-reset so the tie-break starts from its reset value
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: both valid, alternation
        set_req(0, 12'd34, 32'd300, 32'd45, 32'd0);
        set_req(1, 12'd512, 32'd120, 32'd0, 32'd320);
        serve(0, 32'd255, 1'b0);
        serve(1, 32'd440, 1'b0);
        for (int k = 0; k < 4; k++) begin
            set_req(0, 12'd32, 32'(k * 10 + 1), 32'd5, 32'd0);
            set_req(1, 12'd34, 32'd1000, 32'(k), 32'd0);
            serve(0, 32'(k * 10 + 6), 1'b0);
            serve(1, 32'(1000 - k), 1'b0);
        end

        // 3: divide, inputs held for all 8 EXEC cycles
        set_req(1, 12'd26, 32'd100, 32'd7, 32'd0);
        #1;
        check("t3_ready", {30'd0, req_ready_o}, 32'd2);
        @(posedge clk); #1;
        req_valid_i[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t3_alu_cnt", {20'd0, alu_cnt_o}, 32'd26);
            check("t3_alu_rs", alu_rs_o, 32'd100);
            check("t3_alu_rt", alu_rt_o, 32'd7);
            check("t3_busy", {31'd0, rsp_valid_o}, 32'd0);
            @(posedge clk); #1;
        end
        check("t3_valid", {31'd0, rsp_valid_o}, 32'd1);
        check("t3_data", rsp_data_o, 32'd14);
        check("t3_id", {31'd0, rsp_id_o}, 32'd1);
        check("t3_err", {31'd0, rsp_err_o}, 32'd0);
        finish_rsp();

        // 3b: divide by zero skips the ALU
        set_req(1, 12'd26, 32'd5, 32'd0, 32'd0);
        #1;
        check("t3z_ready", {30'd0, req_ready_o}, 32'd2);
        @(posedge clk); #1;
        req_valid_i[1] = 1'b0;
        check("t3z_alu_cnt", {20'd0, alu_cnt_o}, 32'd0);
        check("t3z_valid", {31'd0, rsp_valid_o}, 32'd1);
        check("t3z_data", rsp_data_o, 32'd0);
        check("t3z_err", {31'd0, rsp_err_o}, 32'd1);
        check("t3z_id", {31'd0, rsp_id_o}, 32'd1);
        finish_rsp();

        // 4: response held under back-pressure
        set_req(0, 12'd36, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
        #1;
        @(posedge clk); #1;
        req_valid_i[0] = 1'b0;
        wait_rsp();
        req_valid_i = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("t4_valid", {31'd0, rsp_valid_o}, 32'd1);
            check("t4_data", rsp_data_o, 32'h0000_F000);
            check("t4_id", {31'd0, rsp_id_o}, 32'd0);
            check("t4_err", {31'd0, rsp_err_o}, 32'd0);
            check("t4_ready", {30'd0, req_ready_o}, 32'd0);
        end
        req_valid_i = 2'b00;
        finish_rsp();

        // 5: unsupported code, and OR register form
        set_req(0, 12'd99, 32'd7, 32'd8, 32'd9);
        serve(0, 32'd0, 1'b1);
        set_req(1, 12'd37, 32'd7, 32'd8, 32'd0);
        serve(1, 32'd0, 1'b1);

        // 5b: leave a non-zero result and last_grant=0, then reset mid-MUL
        set_req(0, 12'd832, 32'h10, 32'd0, 32'h3);
        serve(0, 32'h13, 1'b0);
        set_req(0, 12'd24, 32'd6, 32'd7, 32'd0);
        #1;
        @(posedge clk); #1;
        req_valid_i[0] = 1'b0;
        @(posedge clk); #1;
        check("t5_mul_exec", {20'd0, alu_cnt_o}, 32'd24);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_alu_cnt", {20'd0, alu_cnt_o}, 32'd0);
        check("t5_rst_alu_rs", alu_rs_o, 32'd0);
        check("t5_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("t5_rst_data", rsp_data_o, 32'd0);
        check("t5_rst_ready", {30'd0, req_ready_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | rsp_valid_o;
        end
        check("t5_no_rsp", {31'd0, seen_valid}, 32'd0);

        // Tie after reset goes to requester 0 again
        set_req(0, 12'd24, 32'd6, 32'd7, 32'd0);
        set_req(1, 12'd32, 32'd1, 32'd1, 32'd0);
        serve(0, 32'd42, 1'b0);
        serve(1, 32'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
